// File: rtl/regfile_bypass_sb.sv
// Register file with two asynchronous read ports, one synchronous write port,
// write-to-read bypass, optional hardwired zero register and a busy scoreboard.
module regfile_bypass_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [AW-1:0]   AddressRs1,
  input  logic [AW-1:0]   AddressRs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] DataWr,
  input  logic            RFWr,
  output logic [XLEN-1:0] RFrs1,
  output logic [XLEN-1:0] RFrs2,
  input  logic            BusySet,
  input  logic [AW-1:0]   BusyAddr,
  output logic            Rs1Busy,
  output logic            Rs2Busy,
  output logic [AW:0]     BusyCount
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [XLEN-1:0] rf_r [NREGS];
  logic [NREGS-1:0] busy_r;

  logic wr_ok_s;
  logic set_ok_s;
  logic set_hits_rd_s;
  logic inc_s;
  logic dec_s;

  // An address is usable when it is in range and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic in_range_v;
    logic is_zero_v;
    in_range_v = ({1'b0, a} < NREGS_W);
    is_zero_v  = (ZERO_REG != 32'sd0) && (a == {AW{1'b0}});
    return in_range_v && !is_zero_v;
  endfunction

  // Qualified write/set strobes and the scoreboard count delta for this cycle.
  always_comb begin
    wr_ok_s       = 1'b0;
    set_ok_s      = 1'b0;
    set_hits_rd_s = 1'b0;
    inc_s         = 1'b0;
    dec_s         = 1'b0;
    wr_ok_s       = RFWr && addr_ok(rd);
    set_ok_s      = BusySet && addr_ok(BusyAddr);
    set_hits_rd_s = set_ok_s && wr_ok_s && (BusyAddr == rd);
    // A set that lands on the retiring register keeps it busy, so no decrement.
    inc_s         = set_ok_s && !busy_r[BusyAddr];
    dec_s         = wr_ok_s && busy_r[rd] && !set_hits_rd_s;
  end

  // Read port 1 data and pending flag.
  always_comb begin
    RFrs1   = {XLEN{1'b0}};
    Rs1Busy = 1'b0;
    if (!addr_ok(AddressRs1)) begin
      RFrs1   = {XLEN{1'b0}};
      Rs1Busy = 1'b0;
    end else begin
      if ((BYPASS != 32'sd0) && wr_ok_s && (AddressRs1 == rd)) begin
        RFrs1 = DataWr;
      end else begin
        RFrs1 = rf_r[AddressRs1];
      end
      if (wr_ok_s && (AddressRs1 == rd) && !(set_ok_s && (BusyAddr == AddressRs1))) begin
        Rs1Busy = 1'b0;
      end else begin
        Rs1Busy = busy_r[AddressRs1];
      end
    end
  end

  // Read port 2 data and pending flag.
  always_comb begin
    RFrs2   = {XLEN{1'b0}};
    Rs2Busy = 1'b0;
    if (!addr_ok(AddressRs2)) begin
      RFrs2   = {XLEN{1'b0}};
      Rs2Busy = 1'b0;
    end else begin
      if ((BYPASS != 32'sd0) && wr_ok_s && (AddressRs2 == rd)) begin
        RFrs2 = DataWr;
      end else begin
        RFrs2 = rf_r[AddressRs2];
      end
      if (wr_ok_s && (AddressRs2 == rd) && !(set_ok_s && (BusyAddr == AddressRs2))) begin
        Rs2Busy = 1'b0;
      end else begin
        Rs2Busy = busy_r[AddressRs2];
      end
    end
  end

  // Array, scoreboard and count state; the set is applied after the clear so it wins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_r[i] <= {XLEN{1'b0}};
      end
      busy_r    <= {NREGS{1'b0}};
      BusyCount <= {(AW+1){1'b0}};
    end else begin
      if (wr_ok_s) begin
        rf_r[rd]   <= DataWr;
        busy_r[rd] <= 1'b0;
      end
      if (set_ok_s) begin
        busy_r[BusyAddr] <= 1'b1;
      end
      BusyCount <= BusyCount + {{AW{1'b0}}, inc_s} - {{AW{1'b0}}, dec_s};
    end
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: two configurations driven by shared inputs,
// checked every cycle against an array-based model plus hand-computed values.
module tb_regfile_bypass_sb;

  logic        CLK;
  logic        RST;
  logic [4:0]  AddressRs1;
  logic [4:0]  AddressRs2;
  logic [4:0]  rd;
  logic [31:0] DataWr;
  logic        RFWr;
  logic        BusySet;
  logic [4:0]  BusyAddr;

  logic [31:0] RFrs1_a, RFrs2_a, RFrs1_b, RFrs2_b;
  logic        Rs1Busy_a, Rs2Busy_a, Rs1Busy_b, Rs2Busy_b;
  logic [5:0]  BusyCount_a, BusyCount_b;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Config 0: 32 regs, zero reg, bypass. Config 1: 24 regs, no zero reg, no bypass.
  int NR [2] = '{32, 24};
  bit ZR [2] = '{1'b1, 1'b0};
  bit BP [2] = '{1'b1, 1'b0};

  logic [31:0] m_rf   [2][32];
  bit          m_busy [2][32];

  regfile_bypass_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .CLK(CLK), .RST(RST), .AddressRs1(AddressRs1), .AddressRs2(AddressRs2),
    .rd(rd), .DataWr(DataWr), .RFWr(RFWr), .RFrs1(RFrs1_a), .RFrs2(RFrs2_a),
    .BusySet(BusySet), .BusyAddr(BusyAddr), .Rs1Busy(Rs1Busy_a), .Rs2Busy(Rs2Busy_a),
    .BusyCount(BusyCount_a)
  );

  regfile_bypass_sb #(.XLEN(32), .NREGS(24), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .CLK(CLK), .RST(RST), .AddressRs1(AddressRs1), .AddressRs2(AddressRs2),
    .rd(rd), .DataWr(DataWr), .RFWr(RFWr), .RFrs1(RFrs1_b), .RFrs2(RFrs2_b),
    .BusySet(BusySet), .BusyAddr(BusyAddr), .Rs1Busy(Rs1Busy_b), .Rs2Busy(Rs2Busy_b),
    .BusyCount(BusyCount_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_valid(input int c, input int a);
    return (a < NR[c]) && !(ZR[c] && (a == 0));
  endfunction

  function automatic logic [31:0] m_read(input int c, input int a);
    if (!m_valid(c, a)) return 32'h0;
    if (BP[c] && RFWr && m_valid(c, int'(rd)) && (a == int'(rd))) return DataWr;
    return m_rf[c][a];
  endfunction

  function automatic bit m_busy_rd(input int c, input int a);
    bit cleared;
    bit remarked;
    if (!m_valid(c, a)) return 1'b0;
    cleared  = RFWr && m_valid(c, int'(rd)) && (a == int'(rd));
    remarked = BusySet && m_valid(c, int'(BusyAddr)) && (a == int'(BusyAddr));
    if (cleared && !remarked) return 1'b0;
    return m_busy[c][a];
  endfunction

  function automatic int m_count(input int c);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[c][i]);
    return n;
  endfunction

  // Model state update at each rising edge, from the inputs held during the cycle.
  always @(posedge CLK) begin
    for (int c = 0; c < 2; c++) begin
      if (RST) begin
        for (int i = 0; i < 32; i++) begin
          m_rf[c][i]   = 32'h0;
          m_busy[c][i] = 1'b0;
        end
      end else begin
        if (RFWr && m_valid(c, int'(rd))) begin
          m_rf[c][rd]   = DataWr;
          m_busy[c][rd] = 1'b0;
        end
        if (BusySet && m_valid(c, int'(BusyAddr))) m_busy[c][BusyAddr] = 1'b1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("rfrs1_a", 64'(RFrs1_a), 64'(m_read(0, int'(AddressRs1))));
      chk("rfrs2_a", 64'(RFrs2_a), 64'(m_read(0, int'(AddressRs2))));
      chk("rs1busy_a", 64'(Rs1Busy_a), 64'(m_busy_rd(0, int'(AddressRs1))));
      chk("rs2busy_a", 64'(Rs2Busy_a), 64'(m_busy_rd(0, int'(AddressRs2))));
      chk("busycount_a", 64'(BusyCount_a), 64'(m_count(0)));
      chk("rfrs1_b", 64'(RFrs1_b), 64'(m_read(1, int'(AddressRs1))));
      chk("rfrs2_b", 64'(RFrs2_b), 64'(m_read(1, int'(AddressRs2))));
      chk("rs1busy_b", 64'(Rs1Busy_b), 64'(m_busy_rd(1, int'(AddressRs1))));
      chk("rs2busy_b", 64'(Rs2Busy_b), 64'(m_busy_rd(1, int'(AddressRs2))));
      chk("busycount_b", 64'(BusyCount_b), 64'(m_count(1)));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RST = 1'b0; RFWr = 1'b0; BusySet = 1'b0;
  endtask

  initial begin
    RST = 1'b1; RFWr = 1'b0; BusySet = 1'b0;
    AddressRs1 = 5'd0; AddressRs2 = 5'd0; rd = 5'd0; BusyAddr = 5'd0; DataWr = 32'h0;
    tick();
    tick();
    chk_en = 1'b1;
    idle();

    // Reset state over every address.
    for (int a = 0; a < 32; a++) begin
      AddressRs1 = 5'(a); AddressRs2 = 5'(31 - a);
      tick();
    end
    AddressRs1 = 5'd17; #1;
    chk("lit_reset_rd", 64'(RFrs1_a), 64'h0);
    chk("lit_reset_cnt_a", 64'(BusyCount_a), 64'd0);
    chk("lit_reset_cnt_b", 64'(BusyCount_b), 64'd0);

    // Bypass vs. no bypass on a write to 5.
    rd = 5'd5; DataWr = 32'hDEADBEEF; RFWr = 1'b1; AddressRs1 = 5'd5; #1;
    chk("lit_bypass_a", 64'(RFrs1_a), 64'hDEADBEEF);
    chk("lit_nobypass_b", 64'(RFrs1_b), 64'h0);
    tick(); idle(); #1;
    chk("lit_after_wr_a", 64'(RFrs1_a), 64'hDEADBEEF);
    chk("lit_after_wr_b", 64'(RFrs1_b), 64'hDEADBEEF);

    // Register 0: hardwired in config 0, ordinary in config 1.
    rd = 5'd0; DataWr = 32'h12345678; RFWr = 1'b1; BusySet = 1'b1; BusyAddr = 5'd0;
    AddressRs1 = 5'd0;
    tick(); idle(); #1;
    chk("lit_zero_rd_a", 64'(RFrs1_a), 64'h0);
    chk("lit_zero_busy_a", 64'(Rs1Busy_a), 64'd0);
    chk("lit_zero_cnt_a", 64'(BusyCount_a), 64'd0);
    chk("lit_r0_rd_b", 64'(RFrs1_b), 64'h12345678);
    chk("lit_r0_busy_b", 64'(Rs1Busy_b), 64'd1);
    chk("lit_r0_cnt_b", 64'(BusyCount_b), 64'd1);

    // Mark 7 and 9, then retire 7.
    BusySet = 1'b1; BusyAddr = 5'd7; tick();
    BusyAddr = 5'd9; tick(); idle();
    AddressRs1 = 5'd7; #1;
    chk("lit_cnt2_a", 64'(BusyCount_a), 64'd2);
    chk("lit_cnt3_b", 64'(BusyCount_b), 64'd3);
    chk("lit_busy7_a", 64'(Rs1Busy_a), 64'd1);
    rd = 5'd7; DataWr = 32'h00000077; RFWr = 1'b1; #1;
    chk("lit_busy7_clr_a", 64'(Rs1Busy_a), 64'd0);
    tick(); idle(); #1;
    chk("lit_cnt1_a", 64'(BusyCount_a), 64'd1);

    // Set and clear together on 9, then on different registers.
    BusySet = 1'b1; BusyAddr = 5'd9; RFWr = 1'b1; rd = 5'd9; AddressRs1 = 5'd9; #1;
    chk("lit_setwin_comb_a", 64'(Rs1Busy_a), 64'd1);
    tick(); idle(); #1;
    chk("lit_setwin_busy_a", 64'(Rs1Busy_a), 64'd1);
    chk("lit_setwin_cnt_a", 64'(BusyCount_a), 64'd1);
    BusySet = 1'b1; BusyAddr = 5'd3; RFWr = 1'b1; rd = 5'd9;
    tick(); idle(); AddressRs1 = 5'd3; AddressRs2 = 5'd9; #1;
    chk("lit_split_cnt_a", 64'(BusyCount_a), 64'd1);
    chk("lit_split_b3_a", 64'(Rs1Busy_a), 64'd1);
    chk("lit_split_b9_a", 64'(Rs2Busy_a), 64'd0);

    // Out-of-range write on the 24-register config, then reset priority.
    rd = 5'd30; DataWr = 32'hA5A5A5A5; RFWr = 1'b1; AddressRs1 = 5'd30; #1;
    chk("lit_oor_comb_b", 64'(RFrs1_b), 64'h0);
    tick(); idle(); #1;
    chk("lit_oor_b", 64'(RFrs1_b), 64'h0);
    RST = 1'b1; RFWr = 1'b1; rd = 5'd4; DataWr = 32'hCAFEF00D;
    BusySet = 1'b1; BusyAddr = 5'd4; AddressRs1 = 5'd4; #1;
    chk("lit_rst_bypass_a", 64'(RFrs1_a), 64'hCAFEF00D);
    tick(); idle(); #1;
    chk("lit_rst_rd_a", 64'(RFrs1_a), 64'h0);
    chk("lit_rst_busy_a", 64'(Rs1Busy_a), 64'd0);
    chk("lit_rst_cnt_a", 64'(BusyCount_a), 64'd0);
    chk("lit_rst_cnt_b", 64'(BusyCount_b), 64'd0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      RST        = ($urandom_range(0, 199) == 0);
      RFWr       = 1'($urandom_range(0, 1));
      BusySet    = 1'($urandom_range(0, 1));
      rd         = 5'($urandom_range(0, 31));
      BusyAddr   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      AddressRs1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      AddressRs2 = ($urandom_range(0, 2) == 0) ? BusyAddr : 5'($urandom_range(0, 31));
      DataWr     = $urandom;
      tick();
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
- Parametrised successor to the single-cycle core's register unit.
- Provides two asynchronous read ports and one synchronous write port.
- Adds write-to-read bypass, a synchronous reset that clears the array, and an optional hardwired-zero register.
- Adds a per-register busy scoreboard, so pipelined and multicycle cores can detect RAW hazards on pending long-latency results such as loads.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; range 2..64, need not be a power of two.
- AW, $clog2(NREGS), address width; derived, not overridden.
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy.
- BYPASS, 1, when 1, a same-cycle write is forwarded to the read ports.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- AddressRs1  in  AW  read port 1 address.
- AddressRs2  in  AW  read port 2 address.
- rd  in  AW  write address.
- DataWr  in  XLEN  write data.
- RFWr  in  1  write enable.
- RFrs1  out  XLEN  read port 1 data.
- RFrs2  out  XLEN  read port 2 data.
- BusySet  in  1  mark register BusyAddr pending.
- BusyAddr  in  AW  register to mark pending.
- Rs1Busy  out  1  AddressRs1 pending.
- Rs2Busy  out  1  AddressRs2 pending.
- BusyCount  out  AW+1  number of pending registers.

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST). All state changes occur on the rising edge of CLK.
- Reset: when RST=1 at an edge, all registers become 0, all busy bits become 0 and BusyCount becomes 0.
  - RST has priority over RFWr and BusySet in the same cycle.
  - Combinational outputs while RST=1 reflect the pre-reset state; the bypass stays active.
- Write: when RFWr=1 at an edge and rd is valid, RF[rd] <= DataWr. rd is valid when rd < NREGS and not (ZERO_REG=1 and rd=0).
  - Invalid writes are silently dropped.
- Read (combinational, zero latency):
  - Out-of-range address -> 0.
  - Address 0 with ZERO_REG=1 -> 0.
  - BYPASS=1 with RFWr=1, valid rd and address == rd -> DataWr.
  - Otherwise -> RF[address].
  - Both ports may read the same address.
- Scoreboard, busy[i] per register:
  - Set: BusySet=1 and BusyAddr valid (same validity rule as rd) -> busy[BusyAddr] <= 1.
  - Clear: RFWr=1 with valid rd -> busy[rd] <= 0.
  - Set and clear on the same register in the same cycle: set wins; the new producer supersedes the retiring one.
  - Set and clear on different registers in the same cycle: both take effect.
  - Set on an already-busy register: stays 1; BusyCount is unchanged.
  - A write to a non-busy register is legal; the busy bit stays 0.
- Rs1Busy/Rs2Busy (combinational):
  - Value is busy[address], except 0 if a same-cycle RFWr clears that address and no same-cycle BusySet re-marks it.
  - Out-of-range address or zero register -> 0.
  - The busy bypass is independent of the BYPASS parameter.
- BusyCount: registered; always equals the popcount of busy[] after each edge. Updated incrementally: +1, -1, or net 0 when a set and a clear land in the same cycle. Never wraps: the maximum is NREGS-1 with ZERO_REG=1, else NREGS.
- No internal initial-file load; contents are defined only by reset and writes.
- The array must infer as distributed RAM or flops; no latches.

Test Plan:
1. Reset, then read all addresses -> every RFrs1/RFrs2 = 0, Rs1Busy = Rs2Busy = 0, BusyCount = 0.
2. Write rd=5, DataWr=0xDEADBEEF with AddressRs1=5 in the same cycle -> RFrs1 = 0xDEADBEEF before the edge (BYPASS=1), and still after the edge. With BYPASS=0, RFrs1 = old value (0) before the edge, 0xDEADBEEF after.
3. Write rd=0, DataWr=0x12345678; BusySet with BusyAddr=0 -> RFrs1 at address 0 = 0, Rs1Busy = 0, BusyCount = 0 (ZERO_REG=1).
4. BusySet on reg 7, then reg 9 -> BusyCount = 2, Rs1Busy = 1 when AddressRs1 = 7. Then RFWr rd=7 -> Rs1Busy drops the same cycle and BusyCount = 1 after the edge.
5. Same cycle: BusySet on 9 and RFWr rd=9 -> busy[9] stays 1 and BusyCount is unchanged. Same cycle: BusySet on 3 and RFWr rd=9 -> BusyCount is unchanged, busy[3] = 1, busy[9] = 0.
6. NREGS=24: write rd=30 and read address 30 -> write dropped, read = 0. Then assert RST together with RFWr rd=4 and BusySet on 4 -> after the edge reg 4 = 0, busy = 0, BusyCount = 0.
